d_ff_pipe: RTL and testbench



---
 rtl/d_ff_pipe.sv | 87 ++++++++
 tb/tb_d_ff_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: parametrised DEPTH-stage, WIDTH-bit register pipeline with per-stage valid
// tracking, a true clock enable (stall) on a free-running clock, and an occupancy counter.
//
// Optional feature: define D_FF_PIPE_SYNC_CLR_EN to add the i_clear_sync port and the
// synchronous flush logic. Without the macro only i_reset_async empties the pipe.
//
// Parameters:
//   WIDTH        data width in bits (>= 1)
//   DEPTH        number of register stages (>= 1)
//   RESET_VALUE  value loaded into every data stage on reset or clear
// Ports:
//   i_clock        rising-edge clock, free-running
//   i_reset_async  asynchronous active-high reset
//   i_enable       clock enable; 0 = whole pipe holds
//   i_clear_sync   synchronous clear (only with D_FF_PIPE_SYNC_CLR_EN)
//   i_valid        qualifies i_data
//   i_data         input word
//   o_valid        valid bit of the last stage
//   o_data         data of the last stage
//   o_count        number of stages holding valid words
//   o_busy         o_count != 0
module d_ff_pipe #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int unsigned     CW          = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset_async,
  input  logic             i_enable,
`ifdef D_FF_PIPE_SYNC_CLR_EN
  input  logic             i_clear_sync,
`endif
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_busy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Occupancy is maintained incrementally: a word entering and a word leaving on the
  // same edge cancel out, so the counter can never leave 0..DEPTH.
  always_comb begin
    count_d = count_q;
    unique case ({i_valid, valid_q[DEPTH-1]})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset_async) begin
    if (i_reset_async) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
`ifdef D_FF_PIPE_SYNC_CLR_EN
    end else if (i_clear_sync) begin
      // Flush wins over enable; the word presented on this edge is dropped.
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
`endif
    end else if (i_enable) begin
      valid_q[0] <= i_valid;
      data_q[0]  <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
      count_q <= count_d;
    end
  end

  // Last stage drives the outputs directly: no logic after the flops.
  assign o_valid = valid_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];
  assign o_count = count_q;
  assign o_busy  = (count_q != '0);

endmodule

// File: tb/tb_d_ff_pipe.sv
module tb_d_ff_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef D_FF_PIPE_SYNC_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             enable;
  logic             clear;
  logic             valid;
  logic [WIDTH-1:0] data;

  logic             ov0, ovf;
  logic [WIDTH-1:0] od0, odf;
  logic [CW-1:0]    oc0, ocf;
  logic             ob0, obf;

  d_ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(8'h00)) dut (
    .i_clock      (clk),
    .i_reset_async(rst),
    .i_enable     (enable),
`ifdef D_FF_PIPE_SYNC_CLR_EN
    .i_clear_sync (clear),
`endif
    .i_valid      (valid),
    .i_data       (data),
    .o_valid      (ov0),
    .o_data       (od0),
    .o_count      (oc0),
    .o_busy       (ob0)
  );

  d_ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(8'hFF)) dut_ff (
    .i_clock      (clk),
    .i_reset_async(rst),
    .i_enable     (enable),
`ifdef D_FF_PIPE_SYNC_CLR_EN
    .i_clear_sync (clear),
`endif
    .i_valid      (valid),
    .i_data       (data),
    .o_valid      (ovf),
    .o_data       (odf),
    .o_count      (ocf),
    .o_busy       (obf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: independent shift register per instance plus a counter.
  bit               m_v  [DEPTH];
  logic [WIDTH-1:0] m_d0 [DEPTH];
  logic [WIDTH-1:0] m_df [DEPTH];
  int               m_cnt;
  logic [WIDTH-1:0] exp_q [$];

  typedef struct {
    bit               en;
    bit               vld;
    logic [WIDTH-1:0] d;
    bit               exp_ov;
    logic [WIDTH-1:0] exp_od;
    int               exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k]  = 1'b0;
      m_d0[k] = 8'h00;
      m_df[k] = 8'hFF;
    end
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (rst || (clear && CLR_EN)) begin
      model_flush();
    end else if (enable) begin
      if (valid) exp_q.push_back(data);
      if (valid && !m_v[DEPTH-1]) m_cnt++;
      if (!valid && m_v[DEPTH-1]) m_cnt--;
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_v[k]  = m_v[k-1];
        m_d0[k] = m_d0[k-1];
        m_df[k] = m_df[k-1];
      end
      m_v[0]  = valid;
      m_d0[0] = data;
      m_df[0] = data;
    end
  endtask

  task automatic check_outputs();
    int pc;
    pc = 0;
    for (int k = 0; k < DEPTH; k++) pc += int'(m_v[k]);
    chk("ovalid", ov0, m_v[DEPTH-1]);
    chk("odata", od0, m_d0[DEPTH-1]);
    chk("count", oc0, m_cnt);
    chk("count_popcount", oc0, pc);
    chk("busy", ob0, m_cnt != 0);
    chk("count_le_depth", oc0 <= DEPTH, 1);
    chk("ff_ovalid", ovf, m_v[DEPTH-1]);
    chk("ff_odata", odf, m_df[DEPTH-1]);
    chk("ff_count", ocf, m_cnt);
    if (ov0) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("sb_data", od0, exp_q[0]);
        chk("sb_data_ff", odf, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // Drive on the falling edge, model on the rising edge, sample 1ns later.
  task automatic step(input bit en, input bit vld, input bit clr, input logic [WIDTH-1:0] d);
    enable = en;
    valid  = vld;
    clear  = clr;
    data   = d;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic pulse_reset_mid();
    #2 rst = 1'b1;
    data = 8'h3C;
    #1;
    chk("rst_now_ovalid", ov0, 0);
    chk("rst_now_odata", od0, 8'h00);
    chk("rst_now_count", oc0, 0);
    chk("rst_now_busy", ob0, 0);
    chk("rst_now_ff_odata", odf, 8'hFF);
    chk("rst_now_ff_count", ocf, 0);
    model_flush();
    enable = 1'b1;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_count", oc0, 0);
    chk("rst_hold_ff_odata", odf, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    // Streaming A1..A4 then drain, followed by a valid/bubble/valid pattern.
    vecs[0]  = '{1, 1, 8'hA1, 0, 8'h00, 1};
    vecs[1]  = '{1, 1, 8'hA2, 0, 8'h00, 2};
    vecs[2]  = '{1, 1, 8'hA3, 0, 8'h00, 3};
    vecs[3]  = '{1, 1, 8'hA4, 1, 8'hA1, 4};
    vecs[4]  = '{1, 0, 8'h00, 1, 8'hA2, 3};
    vecs[5]  = '{1, 0, 8'h00, 1, 8'hA3, 2};
    vecs[6]  = '{1, 0, 8'h00, 1, 8'hA4, 1};
    vecs[7]  = '{1, 0, 8'h00, 0, 8'h00, 0};
    vecs[8]  = '{1, 1, 8'h11, 0, 8'h00, 1};
    vecs[9]  = '{1, 0, 8'h77, 0, 8'h00, 1};
    vecs[10] = '{1, 1, 8'h33, 0, 8'h00, 2};
    vecs[11] = '{1, 0, 8'h00, 1, 8'h11, 2};
    vecs[12] = '{1, 0, 8'h00, 0, 8'h00, 1};
    vecs[13] = '{1, 0, 8'h00, 1, 8'h33, 1};
    vecs[14] = '{1, 0, 8'h00, 0, 8'h00, 0};

    rst = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    model_flush();
    #1;
    chk("init_ovalid", ov0, 0);
    chk("init_odata", od0, 8'h00);
    chk("init_count", oc0, 0);
    chk("init_ff_odata", odf, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic, then reset asserted between edges.
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 3 != 1), 1'b0, 8'($urandom));
    pulse_reset_mid();

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].en, vecs[i].vld, 1'b0, vecs[i].d);
      chk($sformatf("vec%0d_ovalid", i), ov0, vecs[i].exp_ov);
      chk($sformatf("vec%0d_count", i), oc0, vecs[i].exp_cnt);
      if (vecs[i].exp_ov) chk($sformatf("vec%0d_odata", i), od0, vecs[i].exp_od);
    end

    // Stall: 5A enters, one more enabled edge, 3 held edges, then drain.
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hEE);
      chk("stall_count", oc0, 1);
      chk("stall_ovalid", ov0, 0);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall_not_yet", ov0, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall_emerge_v", ov0, 1);
    chk("stall_emerge_d", od0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 8'h00);

`ifdef D_FF_PIPE_SYNC_CLR_EN
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    chk("clr_full", oc0, 4);
    step(1'b0, 1'b1, 1'b1, 8'h99);
    chk("clr_count", oc0, 0);
    chk("clr_ovalid", ov0, 0);
    chk("clr_odata", od0, 8'h00);
    chk("clr_ff_odata", odf, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("clr_after_ovalid", ov0, 0);
    end
`endif

    // Reset with two words in flight, then a fresh stream at full latency.
    step(1'b1, 1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b1, 1'b0, 8'hB2);
    pulse_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hD1 + i));
    chk("resume_ovalid", ov0, 1);
    chk("resume_odata", od0, 8'hD1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("resume_drained", oc0, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
